bnn_window_gen: RTL and testbench

//   Sliding-window producer for the BNN neuron array. Accepts a raster-order

---
 rtl/bnn_window_gen.sv | 121 ++++++++++++
 tb/tb_bnn_window_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_window_gen.sv
// Sliding KxK window generator over a raster-order binary pixel stream.
// It emits every unpadded window as a flat KERNEL_SIZE-bit vector with a valid/ready handshake.
module bnn_window_gen #(
  parameter int KERNEL_LEN = 3,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  localparam int KERNEL_SIZE = KERNEL_LEN * KERNEL_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [KERNEL_SIZE-1:0] win_out,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic                   frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [0:0] {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_r, state_nxt_s;
  logic [CW-1:0]           col_r;
  logic [RW-1:0]           row_r;
  logic [KERNEL_LEN-2:0]   lb_r [IMG_W];
  logic [KERNEL_SIZE-1:0]  win_r, win_nxt_s;
  logic [KERNEL_LEN-1:0]   col_bits_s;
  logic                    accept_s, emit_s, last_col_s, last_row_s;

  assign pix_ready  = ~win_valid | win_ready;
  assign accept_s   = pix_valid & pix_ready;
  assign last_col_s = (col_r == CW'(IMG_W - 1));
  assign last_row_s = (row_r == RW'(IMG_H - 1));
  // Oldest line-buffer row sits at the top; the incoming pixel is the bottom row.
  assign col_bits_s = {lb_r[col_r], pix_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    emit_s      = 1'b0;
    case (state_r)
      FILL: begin
        if (accept_s && last_col_s && (row_r == RW'(KERNEL_LEN - 2))) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = FILL;
        end
      end
      RUN: begin
        emit_s = accept_s && (col_r >= CW'(KERNEL_LEN - 1));
        if (accept_s && last_col_s && last_row_s) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = FILL;
        emit_s      = 1'b0;
      end
    endcase
  end

  always_comb begin
    win_nxt_s = win_r;
    for (int r = 0; r < KERNEL_LEN; r++) begin
      for (int c = 0; c < KERNEL_LEN - 1; c++) begin
        win_nxt_s[r*KERNEL_LEN + c] = win_r[r*KERNEL_LEN + c + 1];
      end
      win_nxt_s[r*KERNEL_LEN + KERNEL_LEN - 1] = col_bits_s[KERNEL_LEN - 1 - r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r <= '0;
      row_r <= '0;
      win_r <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        lb_r[i] <= '0;
      end
    end else if (accept_s) begin
      lb_r[col_r] <= col_bits_s[KERNEL_LEN-2:0];
      win_r       <= win_nxt_s;
      if (last_col_s) begin
        col_r <= '0;
        row_r <= last_row_s ? '0 : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // A new emit may overwrite only after the previous window has been taken, since emit implies accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_out    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= emit_s && last_col_s && last_row_s;
      if (emit_s) begin
        win_out   <= win_nxt_s;
        win_valid <= 1'b1;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bnn_window_gen.sv
// Scoreboard bench for bnn_window_gen: a reference image model pushes expected windows on accept.
// A monitor pops and compares them on each output handshake.
module tb_bnn_window_gen;

  localparam int K  = 3;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int KS = K * K;

  typedef struct {
    logic [KS-1:0] win;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_in, pix_valid, win_ready;
  logic          pix_ready, win_valid, frame_done;
  logic [KS-1:0] win_out;

  exp_t          q[$];
  logic          img [H][W];
  int            n_cmp = 0, n_fail = 0;
  int            n_win = 0, n_fd = 0, n_hold = 0;
  int            stall_left = 0;
  logic          is_new = 1'b1;
  logic [KS-1:0] held_win = '0;

  bnn_window_gen #(.KERNEL_LEN(K), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .win_out(win_out), .win_valid(win_valid),
    .win_ready(win_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic void gen_frame(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0: img[r][c] = 1'b1;
          1: img[r][c] = 1'((r + c) & 1);
          default: img[r][c] = 1'($urandom_range(0, 1));
        endcase
  endfunction

  function automatic void push_exp(input int r, input int c);
    exp_t e;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        e.win[i*K + j] = img[r-K+1+i][c-K+1+j];
    e.last = (r == H-1) && (c == W-1);
    q.push_back(e);
  endfunction

  // Inputs change at negedge+1; every decision is taken at negedge+4, just before the rising edge.
  task automatic drive_pixel(input int r, input int c);
    int guard = 0;
    @(negedge clk); #1;
    pix_in = img[r][c]; pix_valid = 1'b1;
    win_ready = (stall_left > 0) ? 1'b0 : 1'b1;
    if (stall_left > 0) stall_left--;
    #3;
    while (!pix_ready && guard < 100) begin
      @(negedge clk); #1;
      win_ready = (stall_left > 0) ? 1'b0 : 1'b1;
      if (stall_left > 0) stall_left--;
      #3;
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: pix_ready stuck at %b, required 1", pix_ready);
    end else if (r >= K-1 && c >= K-1) begin
      push_exp(r, c);
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < W*H; i++) drive_pixel(i / W, i % W);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      pix_valid = 1'b0; win_ready = 1'b1;
    end
    #3;
  endtask

  always @(negedge clk) begin
    #4;
    if (rst) begin
      is_new = 1'b1;
    end else begin
      n_cmp++;
      if (pix_ready !== (~win_valid | win_ready)) begin
        n_fail++;
        $display("FAIL pix_ready_rule: got %b, required %b", pix_ready, ~win_valid | win_ready);
      end
      if (win_valid) begin
        if (is_new) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_window: got %h, required none", win_out);
          end else begin
            if (win_out !== q[0].win || frame_done !== q[0].last) begin
              n_fail++;
              $display("FAIL window_data: got win=%h fd=%b, required win=%h fd=%b",
                       win_out, frame_done, q[0].win, q[0].last);
            end
          end
        end else begin
          n_cmp++; n_hold++;
          if (win_out !== held_win || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL window_hold: got win=%h fd=%b, required win=%h fd=0",
                     win_out, frame_done, held_win);
          end
        end
        if (win_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          n_win++;
        end
        held_win = win_out;
        is_new   = win_ready;
      end else begin
        n_cmp++;
        if (frame_done !== 1'b0) begin
          n_fail++;
          $display("FAIL frame_done_idle: got %b, required 0", frame_done);
        end
        is_new = 1'b1;
      end
      if (frame_done) n_fd++;
    end
  end

  task automatic check_frame_totals(input string name, input int w0, input int f0,
                                    input int exp_w, input int exp_f);
    n_cmp++;
    if (n_win - w0 !== exp_w || n_fd - f0 !== exp_f || q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_totals: got windows=%0d done=%0d left=%0d, required %0d %0d 0",
               name, n_win - w0, n_fd - f0, q.size(), exp_w, exp_f);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_in = 1'b0; pix_valid = 1'b0; win_ready = 1'b1;
    #3;
    n_cmp++;
    if (win_out !== '0 || win_valid !== 1'b0 || frame_done !== 1'b0 || pix_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got win=%h v=%b fd=%b rdy=%b, required 0 0 0 1",
               win_out, win_valid, frame_done, pix_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_all_ones();
    int w0 = n_win, f0 = n_fd;
    gen_frame(0);
    send_frame();
    idle(4);
    check_frame_totals("all_ones", w0, f0, 36, 1);
  endtask

  task automatic test_checkerboard();
    int w0 = n_win, f0 = n_fd;
    gen_frame(1);
    send_frame();
    idle(4);
    check_frame_totals("checker", w0, f0, 36, 1);
  endtask

  task automatic test_first_emit();
    int w0 = n_win, f0 = n_fd;
    gen_frame(2);
    for (int i = 0; i < W*H; i++) begin
      drive_pixel(i / W, i % W);
      if (i <= 19) begin
        n_cmp++;
        if (win_valid !== (i == 19)) begin
          n_fail++;
          $display("FAIL first_emit_%0d: got win_valid=%b, required %b", i, win_valid, i == 19);
        end
      end
    end
    idle(4);
    check_frame_totals("first_emit", w0, f0, 36, 1);
  endtask

  task automatic test_backpressure();
    int w0 = n_win, f0 = n_fd, h0 = n_hold;
    gen_frame(2);
    for (int i = 0; i < W*H; i++) begin
      if (i == 3*W + 5) stall_left = 5;
      drive_pixel(i / W, i % W);
    end
    idle(4);
    check_frame_totals("backpressure", w0, f0, 36, 1);
    n_cmp++;
    if (n_hold - h0 < 4) begin
      n_fail++;
      $display("FAIL backpressure_held: got %0d held cycles, required >= 4", n_hold - h0);
    end
  endtask

  task automatic test_mid_reset();
    int w0, f0;
    gen_frame(2);
    for (int i = 0; i < 20; i++) drive_pixel(i / W, i % W);
    @(negedge clk); #1;
    pix_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (win_out !== '0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got win=%h v=%b fd=%b, required 0 0 0",
               win_out, win_valid, frame_done);
    end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    w0 = n_win; f0 = n_fd;
    gen_frame(2);
    send_frame();
    idle(4);
    check_frame_totals("after_reset", w0, f0, 36, 1);
  endtask

  task automatic test_back_to_back();
    int w0 = n_win, f0 = n_fd;
    gen_frame(2);
    send_frame();
    gen_frame(2);
    send_frame();
    idle(4);
    check_frame_totals("back_to_back", w0, f0, 72, 2);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_checkerboard();
    test_first_emit();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
